handshake_constant_gen: RTL and testbench
=========================================

// Module: handshake_constant_gen
// PURPOSE
//  Parametrised successor of the per-token constant source in the handshake datapath.
//  Each control token accepted on ctrl_* produces one data token on outs_*.
//  - MODE 0: the data is a fixed VALUE.
//  - MODE 1: the data is an arithmetic sequence VALUE, VALUE+STRIDE, ... with optional wrap.
//  Optional one-slot output register (OUT_REG) breaks the valid/data path for timing.
// PARAMETERS
//  DATA_WIDTH  32    width of outs
//  VALUE       1000  constant (MODE 0) or sequence start (MODE 1); truncated to DATA_WIDTH
//  MODE        0     0 = constant, 1 = stepping sequence
//  STRIDE      1     increment per token in MODE 1; modulo 2^DATA_WIDTH
//  LIMIT       0     MODE 1 only: 0 = never rewind; N>0 = after N tokens value returns to VALUE
//  OUT_REG     1     0 = combinational pass-through, 1 = one-slot registered output
//  CNT_WIDTH   16    width of the token counter / index
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  ctrl_valid  in   1           control token present
//  ctrl_ready  out  1           control token accepted when ctrl_valid && ctrl_ready
//  outs        out  DATA_WIDTH  generated value
//  outs_valid  out  1           output token present
//  outs_ready  in   1           consumer accepts output token
//  tok_cnt     out  CNT_WIDTH   tokens accepted since reset; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - accept = ctrl_valid && ctrl_ready. All state updates occur on accept only.
//  - Generator state:
//    - cur_val: reset = VALUE.
//    - idx: reset = 0.
//    - MODE 0: cur_val never changes.
//    - MODE 1, on accept:
//      - LIMIT != 0 && idx == LIMIT-1: idx <= 0, cur_val <= VALUE.
//      - otherwise: idx <= idx+1, cur_val <= cur_val+STRIDE, overflow discarded (wrap).
//  - tok_cnt: reset 0, +1 per accept, independent of MODE and LIMIT.
//  - Emitted value of a token = cur_val before that token's update.
//  - OUT_REG = 0 (zero latency, no storage):
//    - outs = cur_val, outs_valid = ctrl_valid, ctrl_ready = outs_ready.
//    - ctrl_ready must not depend on ctrl_valid.
//  - OUT_REG = 1, two states EMPTY / FULL, flag full, reset EMPTY:
//    - ctrl_ready = !full || outs_ready (full throughput; one token per cycle sustained).
//    - On accept: data_q <= cur_val, state FULL.
//    - Else if full && outs_ready: state EMPTY.
//    - Simultaneous drain + accept: stays FULL with new data; no bubble.
//    - outs_valid = full, outs = data_q.
//    - Latency ctrl accept -> outs_valid: 1 cycle.
//  - Output reset values: outs_valid 0; outs 0 (OUT_REG=1) or VALUE (OUT_REG=0); tok_cnt 0;
//    ctrl_ready 1 (OUT_REG=1) or outs_ready (OUT_REG=0).
//  - Reset mid-operation: the buffered token is discarded, the sequence restarts at VALUE, idx 0.
//  - Backpressure: while FULL && !outs_ready, outs and outs_valid hold stable, ctrl_ready = 0,
//    and the generator does not advance.
//  - LIMIT = 1 in MODE 1 behaves as MODE 0.
//  - STRIDE = 0 yields a constant stream but idx and tok_cnt still advance.
// STRUCTURE
//  - Shared package handshake_pkg:
//    - MODE_CONST = 0, MODE_STEP = 1.
//    - Slot state encoding SLOT_EMPTY = 0, SLOT_FULL = 1.
//  - One sub-module: handshake_slot_1 (DATA_WIDTH).
//    - Generic one-slot full-throughput register.
//    - Ports clk, rst, ins/ins_valid/ins_ready, outs/outs_valid/outs_ready.
//    - Instantiated only under OUT_REG = 1 via generate.
//  - Generator (cur_val, idx, tok_cnt) lives in the top module.
// TESTING
//  1. MODE0, VALUE=1000, OUT_REG=1, outs_ready=1, ctrl_valid=1 for 4 cycles ->
//     outs=1000 on 4 consecutive cycles starting 1 cycle later; tok_cnt=4.
//  2. MODE1, VALUE=5, STRIDE=3, LIMIT=4, 6 tokens -> outs 5,8,11,14,5,8; idx back to 0 after the 4th.
//  3. OUT_REG=1, outs_ready=0 for 3 cycles with ctrl_valid=1 ->
//     one token held stable, ctrl_ready=0, generator frozen; release -> next value follows, no loss, no duplicate.
//  4. DATA_WIDTH=8, MODE1, VALUE=250, STRIDE=4, LIMIT=0 -> outs 250,254,2,6 (wrap modulo 256).
//  5. OUT_REG=0, random ctrl_valid/outs_ready -> outs_valid==ctrl_valid, ctrl_ready==outs_ready each cycle;
//     scoreboard matches the sequence.
//  6. Assert rst while FULL mid-sequence (after value 11) -> outs_valid=0 immediately;
//     after release, the first token is VALUE=5 and tok_cnt restarts at 0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared encodings for the handshake datapath blocks.
package handshake_pkg;

    localparam int unsigned MODE_CONST = 0;
    localparam int unsigned MODE_STEP  = 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/handshake_slot_1.sv
// Generic one-slot register with full throughput: a new token may enter
// in the same cycle the held one drains.
module handshake_slot_1
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    slot_state_t           state;
    slot_state_t           state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  full;
    logic                  accept;

    assign full      = (state == SLOT_FULL);
    assign ins_ready = !full || outs_ready;
    assign accept    = ins_valid && ins_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                data_q <= ins;
            end
        end
    end

    // Accept wins over drain so a simultaneous drain+accept stays full.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SLOT_FULL;
        end else if (full && outs_ready) begin
            state_nxt = SLOT_EMPTY;
        end
    end

    assign outs       = data_q;
    assign outs_valid = full;

endmodule

// File: rtl/handshake_constant_gen.sv
// Per-token constant / arithmetic-sequence source: one data token out per
// accepted control token, with an optional one-slot output register.
module handshake_constant_gen
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned VALUE      = 1000,
    parameter int unsigned MODE       = 0,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned LIMIT      = 0,
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  tok_cnt
);

    localparam logic [DATA_WIDTH-1:0] START_VAL = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP_VAL  = DATA_WIDTH'(STRIDE);
    localparam logic [CNT_WIDTH-1:0]  LAST_IDX  = (LIMIT == 0) ? '0 : CNT_WIDTH'(LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] cur_val;
    logic [CNT_WIDTH-1:0]  idx;
    logic                  accept;

    assign accept = ctrl_valid && ctrl_ready;

    // Generator state advances only on an accepted control token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_val <= START_VAL;
            idx     <= '0;
            tok_cnt <= '0;
        end else if (accept) begin
            tok_cnt <= tok_cnt + CNT_ONE;
            if (MODE == MODE_STEP) begin
                if ((LIMIT != 0) && (idx == LAST_IDX)) begin
                    idx     <= '0;
                    cur_val <= START_VAL;
                end else begin
                    idx     <= idx + CNT_ONE;
                    cur_val <= cur_val + STEP_VAL;
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            handshake_slot_1 #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .ins       (cur_val),
                .ins_valid (ctrl_valid),
                .ins_ready (ctrl_ready),
                .outs      (outs),
                .outs_valid(outs_valid),
                .outs_ready(outs_ready)
            );
        end else begin : g_pass
            // Ready is taken from the consumer only, never from ctrl_valid.
            assign outs       = cur_val;
            assign outs_valid = ctrl_valid;
            assign ctrl_ready = outs_ready;
        end
    endgenerate

endmodule

// File: tb/tb_handshake_constant_gen.sv
// Directed bench for handshake_constant_gen across four parameter sets.
module tb_handshake_constant_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u0: constant 1000, registered
    logic        rst0, cv0, cr0, ov0, or0;
    logic [31:0] o0;
    logic [15:0] t0;
    handshake_constant_gen #(.DATA_WIDTH(32), .VALUE(1000), .MODE(0), .OUT_REG(1)) u0 (
        .clk(clk), .rst(rst0), .ctrl_valid(cv0), .ctrl_ready(cr0),
        .outs(o0), .outs_valid(ov0), .outs_ready(or0), .tok_cnt(t0));

    // u1: 5,8,11,14 rewinding, registered
    logic        rst1, cv1, cr1, ov1, or1;
    logic [31:0] o1;
    logic [15:0] t1;
    handshake_constant_gen #(.DATA_WIDTH(32), .VALUE(5), .MODE(1), .STRIDE(3), .LIMIT(4), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst1), .ctrl_valid(cv1), .ctrl_ready(cr1),
        .outs(o1), .outs_valid(ov1), .outs_ready(or1), .tok_cnt(t1));

    // u2: 8-bit wrapping sequence, registered
    logic        rst2, cv2, cr2, ov2, or2;
    logic [7:0]  o2;
    logic [15:0] t2;
    handshake_constant_gen #(.DATA_WIDTH(8), .VALUE(250), .MODE(1), .STRIDE(4), .LIMIT(0), .OUT_REG(1)) u2 (
        .clk(clk), .rst(rst2), .ctrl_valid(cv2), .ctrl_ready(cr2),
        .outs(o2), .outs_valid(ov2), .outs_ready(or2), .tok_cnt(t2));

    // u3: pass-through version of the u1 sequence
    logic        rst3, cv3, cr3, ov3, or3;
    logic [31:0] o3;
    logic [15:0] t3;
    handshake_constant_gen #(.DATA_WIDTH(32), .VALUE(5), .MODE(1), .STRIDE(3), .LIMIT(4), .OUT_REG(0)) u3 (
        .clk(clk), .rst(rst3), .ctrl_valid(cv3), .ctrl_ready(cr3),
        .outs(o3), .outs_valid(ov3), .outs_ready(or3), .tok_cnt(t3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int unsigned exp2 [6]  = '{5, 8, 11, 14, 5, 8};
    int unsigned exp4 [4]  = '{250, 254, 2, 6};
    int unsigned seq5 [8]  = '{5, 8, 11, 14, 5, 8, 11, 14};
    logic        pcv5 [10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    logic        por5 [10] = '{1, 0, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        int k;
        rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1;
        cv0 = 0; cv1 = 0; cv2 = 0; cv3 = 0;
        or0 = 1; or1 = 1; or2 = 1; or3 = 0;
        tick();
        tick();

        // Reset values
        check("rst_u0_valid", 32'(ov0), 32'd0);
        check("rst_u0_outs", o0, 32'd0);
        check("rst_u0_ready", 32'(cr0), 32'd1);
        check("rst_u0_cnt", 32'(t0), 32'd0);
        check("rst_u2_outs", 32'(o2), 32'd0);
        check("rst_u3_outs", o3, 32'd5);
        check("rst_u3_ready", 32'(cr3), 32'd0);
        check("rst_u3_valid", 32'(ov3), 32'd0);
        rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
        tick();

        // Constant stream, one cycle latency
        cv0 = 1;
        #1;
        check("t1_pre_valid", 32'(ov0), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_valid", 32'(ov0), 32'd1);
            check("t1_outs", o0, 32'd1000);
            check("t1_cnt", 32'(t0), 32'(i));
        end
        cv0 = 0;
        tick();
        check("t1_idle_valid", 32'(ov0), 32'd0);
        check("t1_final_cnt", 32'(t0), 32'd4);

        // Rewinding sequence
        cv1 = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_valid", 32'(ov1), 32'd1);
            check("t2_outs", o1, 32'(exp2[i]));
            check("t2_cnt", 32'(t1), 32'(i + 1));
        end
        cv1 = 0;
        tick();
        check("t2_idle_valid", 32'(ov1), 32'd0);

        // Backpressure: 11 is held, generator frozen
        cv1 = 1; or1 = 0;
        tick();
        check("t3_first_outs", o1, 32'd11);
        check("t3_first_cnt", 32'(t1), 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_valid", 32'(ov1), 32'd1);
            check("t3_hold_outs", o1, 32'd11);
            check("t3_hold_ready", 32'(cr1), 32'd0);
            check("t3_hold_cnt", 32'(t1), 32'd7);
        end
        or1 = 1;
        #1;
        check("t3_release_ready", 32'(cr1), 32'd1);
        tick();
        check("t3_next_outs", o1, 32'd14);
        check("t3_next_valid", 32'(ov1), 32'd1);
        check("t3_next_cnt", 32'(t1), 32'd8);
        cv1 = 0;
        tick();
        check("t3_drained_valid", 32'(ov1), 32'd0);
        check("t3_drained_cnt", 32'(t1), 32'd8);

        // 8-bit wrap
        cv2 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_outs", 32'(o2), 32'(exp4[i]));
            check("t4_cnt", 32'(t2), 32'(i + 1));
        end
        cv2 = 0;

        // Pass-through with directed valid/ready pattern
        k = 0;
        for (int i = 0; i < 10; i++) begin
            cv3 = pcv5[i]; or3 = por5[i];
            #1;
            check("t5_valid", 32'(ov3), 32'(pcv5[i]));
            check("t5_ready", 32'(cr3), 32'(por5[i]));
            check("t5_outs", o3, 32'(seq5[k]));
            if (pcv5[i] && por5[i]) k++;
            tick();
        end
        cv3 = 0;
        #1;
        check("t5_cnt", 32'(t3), 32'd6);
        check("t5_next_outs", o3, 32'(seq5[6]));

        // Reset while full mid-sequence
        rst1 = 1;
        tick();
        rst1 = 0;
        cv1 = 1; or1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_outs", o1, 32'(exp2[i]));
        end
        cv1 = 0; or1 = 0;
        tick();
        check("t6_held_outs", o1, 32'd11);
        check("t6_held_valid", 32'(ov1), 32'd1);
        rst1 = 1;
        #1;
        check("t6_rst_valid", 32'(ov1), 32'd0);
        check("t6_rst_cnt", 32'(t1), 32'd0);
        tick();
        rst1 = 0;
        cv1 = 1; or1 = 1;
        tick();
        check("t6_restart_outs", o1, 32'd5);
        check("t6_restart_cnt", 32'(t1), 32'd1);
        cv1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
